// File: rtl/apb_master_bridge_if.sv
// Host request/response channel plus APB master bus for apb_master_bridge.
// The master modport is the bridge view; the slave modport is the host/peripheral side.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_write_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [ADDR_W-1:0] paddr_o;
  logic [DATA_W-1:0] pwdata_o;
  logic [DATA_W-1:0] prdata_i;
  logic              pready_i;
  logic              pslverr_i;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  prdata_i, pready_i, pslverr_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output prdata_i, pready_i, pslverr_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding host-to-APB bridge: IDLE -> SETUP -> ACCESS -> RESP, with
// word-alignment check and an ACCESS-phase timeout that aborts a stalled slave.
module apb_master_bridge #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  apb_master_bridge_if.master bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [7:0]        wait_cnt;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              misaligned;
  logic              timeout_hit;

  assign misaligned  = (bus.req_addr_i[1:0] != 2'b00);
  assign timeout_hit = (wait_cnt == LAST_WAIT);

  assign bus.req_ready_o = (state == ST_IDLE);
  assign bus.rsp_valid_o = (state == ST_RESP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;
  assign bus.psel_o      = psel_q;
  assign bus.penable_o   = penable_q;
  assign bus.pwrite_o    = pwrite_q;
  assign bus.paddr_o     = paddr_q;
  assign bus.pwdata_o    = pwdata_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid_i) begin
            // Misaligned requests never touch the APB bus, so its address/data hold.
            if (misaligned) begin
              state   <= ST_RESP;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state     <= ST_SETUP;
              paddr_q   <= bus.req_addr_i;
              pwrite_q  <= bus.req_write_i;
              pwdata_q  <= bus.req_wdata_i;
              psel_q    <= 1'b1;
              penable_q <= 1'b0;
              wait_cnt  <= '0;
            end
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A ready slave on the final allowed cycle still completes normally.
          if (bus.pready_i) begin
            state     <= ST_RESP;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            err_q     <= bus.pslverr_i;
            rdata_q   <= pwrite_q ? '0 : bus.prdata_i;
          end else if (timeout_hit) begin
            state     <= ST_RESP;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            err_q     <= 1'b1;
            rdata_q   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
